// File: rtl/ex_stage_if.sv
// Bundles the execute stage's stall, pipeline buses and data-SRAM request.
// master = surrounding pipeline/driver side, slave = the execute stage.
interface ex_stage_if;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         ex_is_load;
    logic         stallreq_for_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_rf_bus, ex_is_load, stallreq_for_ex,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_rf_bus, ex_is_load, stallreq_for_ex,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, data-SRAM request, forwarding,
// HI/LO with single-cycle multiply and a 32-iteration restoring divider.
module ex_stage (
    input  logic       clk,
    input  logic       resetn,
    ex_stage_if.slave  ex_if
);
    localparam int   StallBus     = 6;
    localparam int   ID_TO_EX_WD  = 159;
    localparam int   EX_TO_MEM_WD = 76;
    localparam int   EX_TO_RF_WD  = 38;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    logic [StallBus-1:0]    stall;
    logic [ID_TO_EX_WD-1:0] id_ex_reg;

    assign stall = ex_if.stall;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_ex_reg <= '0;
        end else if (stall[2] == Stop && stall[3] == NoStop) begin
            id_ex_reg <= '0;
        end else if (stall[2] == NoStop) begin
            id_ex_reg <= ex_if.id_to_ex_bus;
        end
    end

    logic [31:0] pc, inst, rs_val, rt_val;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en, rf_we, sel_rf_res;
    logic [3:0]  ram_wen;
    logic [4:0]  rf_waddr;

    assign pc         = id_ex_reg[158:127];
    assign inst       = id_ex_reg[126:95];
    assign alu_op     = id_ex_reg[94:83];
    assign sel_src1   = id_ex_reg[82:80];
    assign sel_src2   = id_ex_reg[79:76];
    assign ram_en     = id_ex_reg[75];
    assign ram_wen    = id_ex_reg[74:71];
    assign rf_we      = id_ex_reg[70];
    assign rf_waddr   = id_ex_reg[69:65];
    assign sel_rf_res = id_ex_reg[64];
    assign rs_val     = id_ex_reg[63:32];
    assign rt_val     = id_ex_reg[31:0];

    // One-hot operand selects: an all-zero select collapses to 0.
    logic [31:0] src1_cand [3];
    logic [31:0] src1_mask [3];
    logic [31:0] src2_cand [4];
    logic [31:0] src2_mask [4];
    logic [31:0] src1, src2;

    assign src1_cand[0] = rs_val;
    assign src1_cand[1] = pc;
    assign src1_cand[2] = {27'b0, inst[10:6]};
    assign src2_cand[0] = rt_val;
    assign src2_cand[1] = {{16{inst[15]}}, inst[15:0]};
    assign src2_cand[2] = 32'd8;
    assign src2_cand[3] = {16'b0, inst[15:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src1
            assign src1_mask[gi] = src1_cand[gi] & {32{sel_src1[gi]}};
        end
        for (gi = 0; gi < 4; gi++) begin : g_src2
            assign src2_mask[gi] = src2_cand[gi] & {32{sel_src2[gi]}};
        end
    endgenerate

    assign src1 = src1_mask[0] | src1_mask[1] | src1_mask[2];
    assign src2 = src2_mask[0] | src2_mask[1] | src2_mask[2] | src2_mask[3];

    // ALU candidates indexed by their alu_op bit (bit 11 = add ... bit 0 = lui).
    logic [31:0] alu_cand [12];
    logic [31:0] alu_mask [12];
    logic [31:0] alu_result;

    assign alu_cand[11] = src1 + src2;
    assign alu_cand[10] = src1 - src2;
    assign alu_cand[9]  = {31'b0, $signed(src1) < $signed(src2)};
    assign alu_cand[8]  = {31'b0, src1 < src2};
    assign alu_cand[7]  = src1 & src2;
    assign alu_cand[6]  = ~(src1 | src2);
    assign alu_cand[5]  = src1 | src2;
    assign alu_cand[4]  = src1 ^ src2;
    assign alu_cand[3]  = src2 << src1[4:0];
    assign alu_cand[2]  = src2 >> src1[4:0];
    assign alu_cand[1]  = $signed(src2) >>> src1[4:0];
    assign alu_cand[0]  = {src2[15:0], 16'b0};

    generate
        for (gi = 0; gi < 12; gi++) begin : g_alu
            assign alu_mask[gi] = alu_cand[gi] & {32{alu_op[gi]}};
        end
    endgenerate

    always_comb begin
        alu_result = '0;
        for (int i = 0; i < 12; i++) begin
            alu_result = alu_result | alu_mask[i];
        end
    end

    logic is_special, is_mult, is_multu, is_div, is_divu, is_div_any;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo;

    assign is_special = (inst[31:26] == 6'h00);
    assign is_mult    = is_special && (inst[5:0] == 6'h18);
    assign is_multu   = is_special && (inst[5:0] == 6'h19);
    assign is_div     = is_special && (inst[5:0] == 6'h1A);
    assign is_divu    = is_special && (inst[5:0] == 6'h1B);
    assign is_mfhi    = is_special && (inst[5:0] == 6'h10);
    assign is_mthi    = is_special && (inst[5:0] == 6'h11);
    assign is_mflo    = is_special && (inst[5:0] == 6'h12);
    assign is_mtlo    = is_special && (inst[5:0] == 6'h13);
    assign is_div_any = is_div | is_divu;

    logic [63:0] prod_s, prod_u;
    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    div_state_t  state_reg, state_next;
    logic [4:0]  count_reg;
    logic [31:0] rem_reg, quo_reg, divisor_reg, dividend_reg;
    logic        neg_q_reg, neg_r_reg;
    logic        div_start, div_commit, stallreq;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_start  = 1'b0;
        div_commit = 1'b0;
        stallreq   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (is_div_any) begin
                    state_next = RUN;
                    div_start  = 1'b1;
                    stallreq   = 1'b1;
                end
            end
            RUN: begin
                stallreq = 1'b1;
                if (count_reg == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (stall[3] == NoStop) begin
                    state_next = IDLE;
                    div_commit = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Restoring step: the shifted partial remainder can reach 33 bits.
    logic [32:0] trial_shift, trial_diff;
    logic        q_bit;
    logic [31:0] rem_step, rs_abs, rt_abs, quo_final, rem_final;
    logic        div_zero;

    assign trial_shift = {rem_reg, quo_reg[31]};
    assign trial_diff  = trial_shift - {1'b0, divisor_reg};
    assign q_bit       = ~trial_diff[32];
    assign rem_step    = q_bit ? trial_diff[31:0] : trial_shift[31:0];
    assign rs_abs      = (is_div && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    assign rt_abs      = (is_div && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    assign div_zero    = (divisor_reg == 32'd0);
    assign quo_final   = div_zero ? 32'hFFFF_FFFF : (neg_q_reg ? (32'd0 - quo_reg) : quo_reg);
    assign rem_final   = div_zero ? dividend_reg  : (neg_r_reg ? (32'd0 - rem_reg) : rem_reg);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            divisor_reg  <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
        end else if (div_start) begin
            count_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= rs_abs;
            divisor_reg  <= rt_abs;
            dividend_reg <= rs_val;
            neg_q_reg    <= is_div & (rs_val[31] ^ rt_val[31]);
            neg_r_reg    <= is_div & rs_val[31];
        end else if (state_reg == RUN) begin
            count_reg <= count_reg + 5'd1;
            rem_reg   <= rem_step;
            quo_reg   <= {quo_reg[30:0], q_bit};
        end
    end

    logic [31:0] hi_reg, lo_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (stall[3] == NoStop) begin
            if (div_commit) begin
                hi_reg <= rem_final;
                lo_reg <= quo_final;
            end else if (is_mult) begin
                hi_reg <= prod_s[63:32];
                lo_reg <= prod_s[31:0];
            end else if (is_multu) begin
                hi_reg <= prod_u[63:32];
                lo_reg <= prod_u[31:0];
            end else if (is_mthi) begin
                hi_reg <= rs_val;
            end else if (is_mtlo) begin
                lo_reg <= rs_val;
            end
        end
    end

    logic [31:0]             ex_result;
    logic                    rf_we_eff;
    logic [4:0]              rf_waddr_eff;
    logic [EX_TO_MEM_WD-1:0] mem_bus;
    logic [EX_TO_RF_WD-1:0]  rf_bus;

    assign ex_result    = is_mfhi ? hi_reg : (is_mflo ? lo_reg : alu_result);
    assign rf_we_eff    = rf_we | is_mfhi | is_mflo;
    assign rf_waddr_eff = (is_mfhi | is_mflo) ? inst[15:11] : rf_waddr;
    assign mem_bus      = {pc, ram_en, ram_wen, sel_rf_res, rf_we_eff, rf_waddr_eff, ex_result};
    assign rf_bus       = {rf_we_eff, rf_waddr_eff, ex_result};

    assign ex_if.ex_to_mem_bus   = mem_bus;
    assign ex_if.ex_to_rf_bus    = rf_bus;
    assign ex_if.ex_is_load      = ram_en & sel_rf_res;
    assign ex_if.stallreq_for_ex = stallreq;
    assign ex_if.data_sram_en    = ram_en;
    assign ex_if.data_sram_wen   = (ram_wen != 4'b0) ? 4'b1111 : 4'b0000;
    assign ex_if.data_sram_addr  = ex_result;
    assign ex_if.data_sram_wdata = rt_val;

    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};
endmodule
